// File: rtl/mux_rr_reg_pkg.sv
// mux_rr_reg_pkg: shared mode constants and select-width helper for mux_rr_reg
package mux_rr_reg_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  // select width is at least one bit even for two channels
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_rr_reg_rr_arbiter.sv
// rr_arbiter: first valid channel searching from i_ptr upward with wrap
// Ports: i_valid per-channel request, i_ptr search start, o_grant winning index, o_found any request
module rr_arbiter #(
  parameter int N  = 3,
  parameter int SW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_grant,
  output logic          o_found
);
  function automatic int wrap(input int p, input int k);
    return (p + k >= N) ? p + k - N : p + k;
  endfunction
  // scanning from the far end lets the nearest request to i_ptr win
  always_comb begin
    o_found = 1'b0;
    o_grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_valid[wrap(int'(i_ptr), k)]) begin
        o_found = 1'b1;
        o_grant = SW'(wrap(int'(i_ptr), k));
      end
    end
  end
endmodule

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-channel mux into a registered output stage, fixed or round-robin select
// Ports: s fixed select, in_valid/in_data/in_ready upstream channels,
//        out_valid/out_data/out_chan/out_ready registered output, xfer_count accept counter
module mux_rr_reg
  import mux_rr_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 3,
  parameter int MODE  = MODE_FIXED,
  localparam int SW   = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SW-1:0]      s,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [SW-1:0]      out_chan,
  output logic [15:0]        xfer_count
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_chan;
  logic [SW-1:0]    r_ptr;
  logic [15:0]      r_count;
  logic [SW-1:0]    w_rr_grant;
  logic             w_rr_found;
  logic             w_fix_found;
  logic [SW-1:0]    w_grant;
  logic             w_found;
  logic             w_load;
  logic             w_accept;
  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .i_valid (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_found (w_rr_found)
  );
  // an out-of-range select grants nothing
  assign w_fix_found = (int'(s) < N) && in_valid[s];
  assign w_grant     = (MODE == MODE_RR) ? w_rr_grant : s;
  assign w_found     = (MODE == MODE_RR) ? w_rr_found : w_fix_found;
  assign w_load      = !r_valid || out_ready;
  assign w_accept    = !reset && w_load && w_found;
  assign in_ready    = w_accept ? N'(1) << w_grant : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      if (w_load) r_valid <= w_found;
      if (w_accept) begin
        r_data  <= in_data[int'(w_grant)*WIDTH +: WIDTH];
        r_chan  <= w_grant;
        r_count <= r_count + 16'd1;
        r_ptr   <= (int'(w_grant) == N - 1) ? '0 : w_grant + SW'(1);
      end
    end
  end
  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_chan   = r_chan;
  assign xfer_count = r_count;
endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: directed checks of mux_rr_reg in fixed and round-robin modes
module tb_mux_rr_reg;
  logic        clk = 0;
  logic [47:0] in_data = {16'h0030, 16'h0020, 16'h0010};
  logic        reset0 = 1, reset1 = 1;
  logic [1:0]  s0 = 0, s1 = 0;
  logic [2:0]  iv0 = 0, iv1 = 0;
  logic        or0 = 1, or1 = 1;
  logic [2:0]  ir0, ir1;
  logic        ov0, ov1;
  logic [15:0] od0, od1, cnt0, cnt1;
  logic [1:0]  oc0, oc1;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mux_rr_reg #(.WIDTH(16), .N(3), .MODE(0)) d0 (
    .clk(clk), .reset(reset0), .s(s0), .in_valid(iv0), .in_data(in_data), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(or0), .out_chan(oc0), .xfer_count(cnt0)
  );
  mux_rr_reg #(.WIDTH(16), .N(3), .MODE(1)) d1 (
    .clk(clk), .reset(reset1), .s(s1), .in_valid(iv1), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(or1), .out_chan(oc1), .xfer_count(cnt1)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    iv0 = 3'b111; iv1 = 3'b111;
    #1;
    n_checks++; if (ir0 !== 3'b000) begin n_fail++; $display("FAIL reset_ready0 got %b want 000", ir0); end
    n_checks++; if (ir1 !== 3'b000) begin n_fail++; $display("FAIL reset_ready1 got %b want 000", ir1); end
    step();
    n_checks++; if ({ov0, od0, oc0, cnt0} !== 35'd0) begin n_fail++; $display("FAIL reset_out0 got v=%b d=%h c=%0d n=%h want zeros", ov0, od0, oc0, cnt0); end
    n_checks++; if ({ov1, od1, oc1, cnt1} !== 35'd0) begin n_fail++; $display("FAIL reset_out1 got v=%b d=%h c=%0d n=%h want zeros", ov1, od1, oc1, cnt1); end
    iv0 = 0; iv1 = 0;
    reset0 = 0; reset1 = 0;
  endtask
  task automatic test_fixed();
    logic [2:0] er;
    logic [15:0] ed;
    iv0 = 3'b111; or0 = 1;
    for (int k = 0; k < 3; k++) begin
      s0 = 2'(k);
      er = 3'b001 << k;
      ed = 16'h0010 * 16'(k + 1);
      #1;
      n_checks++; if (ir0 !== er) begin n_fail++; $display("FAIL fixed_ready s=%0d got %b want %b", k, ir0, er); end
      step();
      n_checks++; if (od0 !== ed || oc0 !== 2'(k) || ov0 !== 1'b1) begin n_fail++; $display("FAIL fixed_out s=%0d got d=%h c=%0d v=%b want d=%h c=%0d v=1", k, od0, oc0, ov0, ed, k); end
    end
    n_checks++; if (cnt0 !== 16'd3) begin n_fail++; $display("FAIL fixed_count got %0d want 3", cnt0); end
  endtask
  task automatic test_fixed_none();
    s0 = 2'd3;
    #1;
    n_checks++; if (ir0 !== 3'b000) begin n_fail++; $display("FAIL none_ready got %b want 000", ir0); end
    step();
    n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL none_drain got v=%b want 0", ov0); end
    step();
    n_checks++; if (cnt0 !== 16'd3) begin n_fail++; $display("FAIL none_count got %0d want 3", cnt0); end
  endtask
  task automatic test_rr();
    iv1 = 3'b111; or1 = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++; if (oc1 !== 2'(k % 3) || od1 !== 16'h0010 * 16'(k % 3 + 1)) begin n_fail++; $display("FAIL rr_seq k=%0d got c=%0d d=%h want c=%0d", k, oc1, od1, k % 3); end
    end
    n_checks++; if (cnt1 !== 16'd6) begin n_fail++; $display("FAIL rr_count got %0d want 6", cnt1); end
  endtask
  task automatic test_rr_wrap();
    iv1 = 3'b100;
    #1;
    n_checks++; if (ir1 !== 3'b100) begin n_fail++; $display("FAIL wrap_ready got %b want 100", ir1); end
    step();
    n_checks++; if (oc1 !== 2'd2 || od1 !== 16'h0030) begin n_fail++; $display("FAIL wrap_grant got c=%0d d=%h want c=2 d=0030", oc1, od1); end
    iv1 = 3'b011;
    #1;
    n_checks++; if (ir1 !== 3'b001) begin n_fail++; $display("FAIL wrap_ptr got %b want 001", ir1); end
    step();
    n_checks++; if (oc1 !== 2'd0 || cnt1 !== 16'd8) begin n_fail++; $display("FAIL wrap_next got c=%0d n=%0d want c=0 n=8", oc1, cnt1); end
    iv1 = 0;
  endtask
  task automatic test_stall();
    s0 = 1; iv0 = 3'b111; or0 = 1;
    step();
    n_checks++; if (ov0 !== 1'b1 || od0 !== 16'h0020 || oc0 !== 2'd1) begin n_fail++; $display("FAIL stall_load got v=%b d=%h c=%0d want 1 0020 1", ov0, od0, oc0); end
    or0 = 0;
    for (int k = 0; k < 4; k++) begin
      s0 = 2'(k % 3);
      iv0 = 3'(k + 1);
      #1;
      n_checks++; if (ir0 !== 3'b000) begin n_fail++; $display("FAIL stall_ready k=%0d got %b want 000", k, ir0); end
      step();
      n_checks++; if (ov0 !== 1'b1 || od0 !== 16'h0020 || oc0 !== 2'd1) begin n_fail++; $display("FAIL stall_hold k=%0d got v=%b d=%h c=%0d want 1 0020 1", k, ov0, od0, oc0); end
    end
    or0 = 1; s0 = 2; iv0 = 3'b111;
    step();
    n_checks++; if (ov0 !== 1'b1 || od0 !== 16'h0030 || oc0 !== 2'd2 || cnt0 !== 16'd5) begin n_fail++; $display("FAIL drain_accept got v=%b d=%h c=%0d n=%0d want 1 0030 2 5", ov0, od0, oc0, cnt0); end
  endtask
  task automatic test_count_wrap();
    reset0 = 1; reset1 = 1;
    step();
    reset0 = 0; reset1 = 0;
    s0 = 0; iv0 = 3'b001; or0 = 1;
    iv1 = 3'b111; or1 = 1;
    for (int k = 0; k < 65535; k++) step();
    n_checks++; if (cnt0 !== 16'hFFFF || ov0 !== 1'b1) begin n_fail++; $display("FAIL count_full0 got n=%h v=%b want ffff 1", cnt0, ov0); end
    n_checks++; if (cnt1 !== 16'hFFFF) begin n_fail++; $display("FAIL count_full1 got %h want ffff", cnt1); end
    reset0 = 1;
    #1;
    n_checks++; if (ir0 !== 3'b000) begin n_fail++; $display("FAIL midreset_ready got %b want 000", ir0); end
    step();
    n_checks++; if ({ov0, od0, oc0, cnt0} !== 35'd0) begin n_fail++; $display("FAIL midreset_out got v=%b d=%h c=%0d n=%h want zeros", ov0, od0, oc0, cnt0); end
    n_checks++; if (cnt1 !== 16'h0000 || ov1 !== 1'b1) begin n_fail++; $display("FAIL count_wrap got n=%h v=%b want 0000 1", cnt1, ov1); end
    reset0 = 0;
  endtask
  initial begin
    test_reset();
    test_fixed();
    test_fixed_none();
    test_rr();
    test_rr_wrap();
    test_stall();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 Parameter WIDTH, default 16, data width of every input channel and of the output.
REQ-002 Parameter N, default 3, number of input channels, legal range 2..16.
REQ-003 Parameter MODE, default 0, 0 = fixed select via s, 1 = round-robin arbitration (s ignored).
REQ-004 Ports (name  direction  width  meaning):
  clk  in  1  single clock, all state on rising edge;
  reset  in  1  synchronous, active-high reset;
  s  in  SW = max(1, ceil(log2 N))  channel select (MODE 0 only);
  in_valid  in  N  per-channel data valid;
  in_data  in  N*WIDTH  flattened channel data, channel i at bits [i*WIDTH +: WIDTH];
  in_ready  out  N  per-channel accept strobe;
  out_valid  out  1  output register holds data;
  out_data  out  WIDTH  registered selected data;
  out_ready  in  1  downstream accept;
  out_chan  out  SW  channel index of the data in out_data;
  xfer_count  out  16  number of accepted transfers, modulo 2^16.
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-006 load = (!out_valid || out_ready); the output register SHALL accept one word per cycle when load is high and a grant exists.
REQ-007 MODE 0: the grant SHALL be channel s when in_valid[s]=1 and s<N; no grant otherwise (s>=N selects nothing).
REQ-008 MODE 1: the grant SHALL be the first channel with in_valid=1 found searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-009 MODE 1: on each accept, ptr SHALL become (granted index + 1) modulo N, wrapping N-1 to 0; ptr SHALL hold when no accept occurs.
REQ-010 in_ready[i] SHALL be combinational: high only when i is granted and load=1; at most one bit of in_ready SHALL be high.
REQ-011 On accept, out_data SHALL take in_data of the granted channel, out_chan the index, out_valid 1, one cycle latency.
REQ-012 When out_valid=1 and out_ready=0, out_data, out_chan, out_valid SHALL hold unchanged.
REQ-013 When out_valid=1, out_ready=1 and no grant exists, out_valid SHALL clear next cycle.
REQ-014 Simultaneous drain and accept SHALL sustain one word per cycle without a bubble.
REQ-015 xfer_count SHALL increment by 1 per accept and wrap from 16'hFFFF to 0.
REQ-016 Changes of s while out_valid=1 and stalled SHALL not alter the held output.

Reset
REQ-017 With reset high at a rising edge: out_valid=0, out_data=0, out_chan=0, ptr=0, xfer_count=0.
REQ-018 in_ready SHALL be all-zero whenever reset is high.
REQ-019 Reset mid-transfer SHALL discard held data; no accept SHALL occur in a cycle where reset is high.

Structure
REQ-020 Shared package SHALL hold MODE_FIXED=0, MODE_RR=1 constants and the select-width function SW(N).
REQ-021 The round-robin grant logic (valid vector, ptr -> grant index, grant-found) SHALL be a sub-module rr_arbiter; MODE 0 bypasses it.
REQ-022 RTL SHALL be synthesisable, no latches, single always block for sequential state.

Verification
REQ-023 Bench SHALL run with WIDTH=16, N=3 in both modes and cover:
  V1 MODE 0, s=0..2 each, in_data={16'h0030,16'h0020,16'h0010}, all valid, out_ready=1 -> out_data equals selected channel one cycle later, out_chan=s.
  V2 MODE 0, s=3 -> in_ready=0, out_valid drops after drain, xfer_count unchanged.
  V3 MODE 1, all valid, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,0,1,2, xfer_count=6.
  V4 MODE 1, only in_valid[2]=1 with ptr=0 -> channel 2 granted, ptr becomes 0 (wrap).
  V5 out_ready=0 with out_valid=1 for 4 cycles while inputs change -> out_data/out_chan constant, in_ready all zero.
  V6 reset asserted with out_valid=1 and xfer_count=16'hFFFF -> all outputs zero next cycle; separate run: 65536 accepts -> xfer_count wraps to 0.
